// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_pkg : shared AES byte type, widths and forward S-box table      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_WORD_W = 32;
  localparam int AES_BYTE_W = 8;

  typedef logic [AES_BYTE_W-1:0] aes_byte_t;

  localparam aes_byte_t AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic aes_byte_t aes_sbox(input aes_byte_t b);
    return AES_SBOX[b];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_byte.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_sbox_byte : combinational forward S-box lookup, 8 bits in/out   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module aes_sbox_byte
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
  output logic [AES_BYTE_W-1:0] out_byte
);

  assign out_byte = aes_sbox(in_byte);

endmodule
`default_nettype wire

// File: rtl/s_bytes.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | s_bytes : registered AES SubBytes stage, 1-cycle latency            |
// | Optional out_parity port enabled by S_BYTES_PARITY_EN. Rev 1.0      |
// +--------------------------------------------------------------------+
module s_bytes
  import aes_pkg::*;
#(
  parameter int NWords = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [AES_WORD_W*NWords-1:0] state_in,
  output logic                       out_valid,
  output logic [AES_WORD_W*NWords-1:0] state_out
`ifdef S_BYTES_PARITY_EN
  ,
  output logic [4*NWords-1:0]        out_parity
`endif
);

  localparam int NBytes  = 4 * NWords;
  localparam int StateW  = AES_WORD_W * NWords;

  logic [StateW-1:0] w_sub;
  logic [StateW-1:0] state_d, state_q;
  logic              valid_d, valid_q;

  for (genvar k = 0; k < NBytes; k++) begin : g_byte
    aes_sbox_byte u_sbox (
      .in_byte  (state_in[k*AES_BYTE_W +: AES_BYTE_W]),
      .out_byte (w_sub[k*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  // Idle cycles keep the old state so an X on state_in never reaches the flops.
  always_comb begin
    valid_d = in_valid;
    state_d = state_q;
    if (in_valid) state_d = w_sub;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      state_q <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign out_valid = valid_q;
  assign state_out = state_q;

`ifdef S_BYTES_PARITY_EN
  logic [NBytes-1:0] parity_d, parity_q;

  always_comb begin
    parity_d = parity_q;
    if (in_valid) begin
      for (int k = 0; k < NBytes; k++) begin
        parity_d[k] = ^w_sub[k*AES_BYTE_W +: AES_BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= '0;
    else        parity_q <= parity_d;
  end

  assign out_parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_s_bytes.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_s_bytes : scoreboard bench for s_bytes (NWords=4 and NWords=2)   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_s_bytes;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_valid2;
  logic [127:0] state_in, state_out;
  logic [63:0]  state_in2, state_out2;
  logic         out_valid, out_valid2;
`ifdef S_BYTES_PARITY_EN
  logic [15:0]  out_parity;
  logic [7:0]   out_parity2;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] q4[$];
  logic [63:0]  q2[$];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ROW_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ROW_OUT  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] ZERO_IN  = 128'h0;
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};
  localparam logic [127:0] ONES_IN  = {16{8'hff}};
  localparam logic [127:0] ONES_OUT = {16{8'h16}};

  always #5 clk = ~clk;

  s_bytes #(.NWords(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .state_in  (state_in),
    .out_valid (out_valid),
    .state_out (state_out)
`ifdef S_BYTES_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  s_bytes #(.NWords(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .state_in  (state_in2),
    .out_valid (out_valid2),
    .state_out (state_out2)
`ifdef S_BYTES_PARITY_EN
    ,
    .out_parity(out_parity2)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] byte_par(input logic [127:0] s);
    logic [15:0] p;
    for (int k = 0; k < 16; k++) p[k] = ^s[k*8 +: 8];
    return p;
  endfunction

  // Monitor: pops one expectation per presented output.
  initial begin
    logic [127:0] e4;
    logic [63:0]  e2;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q4.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid4: got state %h with empty scoreboard", state_out);
        end else begin
          e4 = q4.pop_front();
          chk("state_out4", state_out, e4);
`ifdef S_BYTES_PARITY_EN
          chk("parity4", {112'd0, out_parity}, {112'd0, byte_par(e4)});
`endif
        end
      end
      if (out_valid2 === 1'b1) begin
        if (q2.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid2: got state %h with empty scoreboard", state_out2);
        end else begin
          e2 = q2.pop_front();
          chk("state_out2", {64'd0, state_out2}, {64'd0, e2});
`ifdef S_BYTES_PARITY_EN
          chk("parity2", {120'd0, out_parity2}, {120'd0, byte_par({64'd0, e2})[7:0]});
`endif
        end
      end
    end
  end

  // Drives a burst of back-to-back valid states; returns 1 ns after the last capture edge.
  task automatic send(input logic [127:0] din [], input logic [127:0] dexp []);
    for (int i = 0; i < din.size(); i++) begin
      state_in = din[i];
      in_valid = 1'b1;
      q4.push_back(dexp[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    state_in = 'x;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    state_in  = '0;
    state_in2 = '0;
    idle(2);
    chk("reset_state", state_out, 128'd0);
    chk("reset_valid", {127'd0, out_valid}, 128'd0);
    rst_n = 1'b1;
    idle(1);

    // FIPS vector followed by a hold cycle
    send('{FIPS_IN}, '{FIPS_OUT});
    idle(1);
    chk("hold_valid", {127'd0, out_valid}, 128'd0);
    chk("hold_state", state_out, FIPS_OUT);

    send('{ROW_IN}, '{ROW_OUT});   idle(1);
    send('{ZERO_IN}, '{ZERO_OUT}); idle(1);
    send('{ONES_IN}, '{ONES_OUT}); idle(1);

    // Streaming: three consecutive accepted states
    send('{ZERO_IN, ONES_IN, FIPS_IN}, '{ZERO_OUT, ONES_OUT, FIPS_OUT});
    idle(2);
    chk("stream_drained", 128'(q4.size()), 128'd0);

    // Asynchronous reset between edges while out_valid is high
    send('{ROW_IN}, '{ROW_OUT});
    #2;
    rst_n = 1'b0;
    q4.delete();
    #1;
    chk("async_rst_state", state_out, 128'd0);
    chk("async_rst_valid", {127'd0, out_valid}, 128'd0);
`ifdef S_BYTES_PARITY_EN
    chk("async_rst_parity", {112'd0, out_parity}, 128'd0);
`endif
    state_in = FIPS_IN;
    in_valid = 1'b1;
    idle(2);
    chk("rst_override_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_override_state", state_out, 128'd0);
    in_valid = 1'b0;
    state_in = 'x;
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_idle", {127'd0, out_valid}, 128'd0);
    send('{FIPS_IN}, '{FIPS_OUT});
    idle(1);

    // NWords=2 instance
    state_in2 = 64'h0001020304050607;
    in_valid2 = 1'b1;
    q2.push_back(64'h637c777bf26b6fc5);
    idle(1);
    in_valid2 = 1'b0;
    idle(2);
    chk("nw2_hold_state", {64'd0, state_out2}, {64'd0, 64'h637c777bf26b6fc5});

    chk("scoreboard4_empty", 128'(q4.size()), 128'd0);
    chk("scoreboard2_empty", 128'(q2.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
